// File: rtl/controller.sv
// Single-cycle RV32I main decoder: combinational control word from inst, plus a
// sticky flag recording whether any illegal encoding has been clocked since reset.
module controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  output logic        reg_wr,
  output logic        rd_en,
  output logic        wr_en,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  wb_sel,
  output logic [2:0]  br_type,
  output logic [3:0]  alu_op,
  output logic        illegal_inst,
  output logic        illegal_seen
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_I     = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_BR    = 7'b1100011,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL  = 4'b0010, ALU_SLT = 4'b0011,
    ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101, ALU_SRL  = 4'b0110, ALU_SRA = 4'b0111,
    ALU_OR   = 4'b1000, ALU_AND = 4'b1001, ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic       reg_wr;
    logic       rd_en;
    logic       wr_en;
    logic       sel_a;
    logic       sel_b;
    logic [1:0] wb_sel;
    logic [2:0] br_type;
    alu_op_e    alu_op;
  } ctrl_t;

  localparam logic [1:0] WB_PC4 = 2'b00, WB_ALU = 2'b01, WB_MEM = 2'b10;
  localparam logic [2:0] BR_NONE = 3'b000, BR_JUMP = 3'b111;

  opcode_e    opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_zero, f7_alt, is_imm;
  alu_op_e    alu_sel;
  logic       alu_ok;
  logic [2:0] br_sel;
  logic       br_ok;
  ctrl_t      ctrl;
  logic       illegal;
  logic       illegal_seen_d, illegal_seen_q;

  assign opcode  = opcode_e'(inst[6:0]);
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);
  assign is_imm  = (opcode == OP_I);

  // Shared ALU mapping for R-type and I-type; immediates ignore funct7 except on shifts.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_sel = ALU_ADD;
    alu_ok  = 1'b0;
    unique case (funct3)
      3'b000: begin
        alu_sel = (!is_imm && f7_alt) ? ALU_SUB : ALU_ADD;
        alu_ok  = is_imm || f7_zero || f7_alt;
      end
      3'b001: begin alu_sel = ALU_SLL;  alu_ok = f7_zero;           end
      3'b010: begin alu_sel = ALU_SLT;  alu_ok = is_imm || f7_zero; end
      3'b011: begin alu_sel = ALU_SLTU; alu_ok = is_imm || f7_zero; end
      3'b100: begin alu_sel = ALU_XOR;  alu_ok = is_imm || f7_zero; end
      3'b101: begin
        alu_sel = f7_alt ? ALU_SRA : ALU_SRL;
        alu_ok  = f7_zero || f7_alt;
      end
      3'b110: begin alu_sel = ALU_OR;   alu_ok = is_imm || f7_zero; end
      3'b111: begin alu_sel = ALU_AND;  alu_ok = is_imm || f7_zero; end
      default: ;
    endcase
  end

  always_comb begin
    br_sel = BR_NONE;
    br_ok  = 1'b1;
    case (funct3)
      3'b000:  br_sel = 3'b001;
      3'b001:  br_sel = 3'b010;
      3'b100:  br_sel = 3'b011;
      3'b101:  br_sel = 3'b100;
      3'b110:  br_sel = 3'b101;
      3'b111:  br_sel = 3'b110;
      default: br_ok  = 1'b0;
    endcase
  end

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R:     begin ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, WB_ALU, BR_NONE, alu_sel}; illegal = !alu_ok; end
      OP_I:     begin ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, WB_ALU, BR_NONE, alu_sel}; illegal = !alu_ok; end
      OP_LOAD:  ctrl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, WB_MEM, BR_NONE, ALU_ADD};
      OP_STORE: ctrl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, WB_ALU, BR_NONE, ALU_ADD};
      OP_BR:    begin ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WB_ALU, br_sel, ALU_ADD}; illegal = !br_ok; end
      OP_JAL:   ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, WB_PC4, BR_JUMP, ALU_ADD};
      OP_JALR:  begin ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, WB_PC4, BR_JUMP, ALU_ADD}; illegal = (funct3 != 3'b000); end
      OP_LUI:   ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, WB_ALU, BR_NONE, ALU_PASSB};
      OP_AUIPC: ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, WB_ALU, BR_NONE, ALU_ADD};
      default:  illegal = 1'b1;
    endcase
    // Illegal encodings and an asserted reset both collapse to a NOP.
    if (illegal || !rst_n) ctrl = '0;
    if (!rst_n) illegal = 1'b0;
  end

  assign reg_wr       = ctrl.reg_wr;
  assign rd_en        = ctrl.rd_en;
  assign wr_en        = ctrl.wr_en;
  assign sel_A        = ctrl.sel_a;
  assign sel_B        = ctrl.sel_b;
  assign wb_sel       = ctrl.wb_sel;
  assign br_type      = ctrl.br_type;
  assign alu_op       = ctrl.alu_op;
  assign illegal_inst = illegal;

  assign illegal_seen_d = illegal_seen_q | illegal;

  // NOTE: sequential state uses non-blocking assignments, and the async reset branch comes first so it wins over a coincident edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_seen_q <= 1'b0;
    else        illegal_seen_q <= illegal_seen_d;
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: expected control words are queued on drive and
// popped when the combinational outputs are sampled.
module tb_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic        reg_wr, rd_en, wr_en, sel_A, sel_B, illegal_inst, illegal_seen;
  logic [1:0]  wb_sel;
  logic [2:0]  br_type;
  logic [3:0]  alu_op;

  int n_checks = 0;
  int n_pass   = 0;
  logic [14:0] exp_q[$];
  logic        seen_model = 1'b0;

  controller dut (
    .clk(clk), .rst_n(rst_n), .inst(inst),
    .reg_wr(reg_wr), .rd_en(rd_en), .wr_en(wr_en), .sel_A(sel_A), .sel_B(sel_B),
    .wb_sel(wb_sel), .br_type(br_type), .alu_op(alu_op),
    .illegal_inst(illegal_inst), .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  // Expected row: {reg_wr,rd_en,wr_en,sel_A,sel_B,wb_sel,br_type,alu_op,illegal_inst}
  function automatic logic [14:0] row(input logic [4:0] flags, input logic [1:0] wb,
                                      input logic [2:0] br, input logic [3:0] alu, input logic ill);
    return {flags, wb, br, alu, ill};
  endfunction

  function automatic logic [14:0] observed();
    return {reg_wr, rd_en, wr_en, sel_A, sel_B, wb_sel, br_type, alu_op, illegal_inst};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pop the oldest expectation and compare it against the current outputs.
  task automatic compare_head(input string tag);
    logic [14:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check(tag, {17'd0, observed()}, {17'd0, e});
    check({tag, " seen"}, {31'd0, illegal_seen}, {31'd0, seen_model});
    check({tag, " rd/wr exclusive"}, {31'd0, (rd_en & wr_en) | (wr_en & reg_wr)}, 32'd0);
  endtask

  task automatic apply(input string tag, input logic [31:0] i, input logic [14:0] e);
    @(negedge clk);
    inst = i;
    exp_q.push_back(e);
    #1;
    compare_head(tag);
    if (e[0] && rst_n) seen_model = 1'b1;  // takes effect at the coming posedge
  endtask

  localparam logic [14:0] NOP_ILL = 15'b0000_0_00_000_0000_1;

  initial begin
    // Reset held with ADD applied: everything forced low.
    inst = mk(7'h00, 3'b000, 7'b0110011);
    exp_q.push_back('0);
    #12;
    compare_head("reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(row(5'b10010, 2'b01, 3'b000, 4'b0000, 1'b0));
    #1;
    compare_head("reset release ADD");

    apply("ADD",   mk(7'h00, 3'b000, 7'b0110011), row(5'b10010, 2'b01, 3'b000, 4'b0000, 1'b0));
    apply("AND",   mk(7'h00, 3'b111, 7'b0110011), row(5'b10010, 2'b01, 3'b000, 4'b1001, 1'b0));
    apply("SUB",   mk(7'h20, 3'b000, 7'b0110011), row(5'b10010, 2'b01, 3'b000, 4'b0001, 1'b0));
    apply("SRA",   mk(7'h20, 3'b101, 7'b0110011), row(5'b10010, 2'b01, 3'b000, 4'b0111, 1'b0));
    apply("SLTU",  mk(7'h00, 3'b011, 7'b0110011), row(5'b10010, 2'b01, 3'b000, 4'b0100, 1'b0));
    apply("ADDI",  mk(7'h55, 3'b000, 7'b0010011), row(5'b10011, 2'b01, 3'b000, 4'b0000, 1'b0));
    apply("SLLI",  mk(7'h00, 3'b001, 7'b0010011), row(5'b10011, 2'b01, 3'b000, 4'b0010, 1'b0));
    apply("SRAI",  mk(7'h20, 3'b101, 7'b0010011), row(5'b10011, 2'b01, 3'b000, 4'b0111, 1'b0));
    apply("XORI",  mk(7'h7f, 3'b100, 7'b0010011), row(5'b10011, 2'b01, 3'b000, 4'b0101, 1'b0));
    apply("LW",    mk(7'h00, 3'b010, 7'b0000011), row(5'b11011, 2'b10, 3'b000, 4'b0000, 1'b0));
    apply("SW",    mk(7'h00, 3'b010, 7'b0100011), row(5'b00111, 2'b01, 3'b000, 4'b0000, 1'b0));
    apply("BEQ",   mk(7'h00, 3'b000, 7'b1100011), row(5'b00001, 2'b01, 3'b001, 4'b0000, 1'b0));
    apply("BLT",   mk(7'h00, 3'b100, 7'b1100011), row(5'b00001, 2'b01, 3'b011, 4'b0000, 1'b0));
    apply("BGEU",  mk(7'h00, 3'b111, 7'b1100011), row(5'b00001, 2'b01, 3'b110, 4'b0000, 1'b0));
    apply("JAL",   mk(7'h12, 3'b101, 7'b1101111), row(5'b10001, 2'b00, 3'b111, 4'b0000, 1'b0));
    apply("JALR",  mk(7'h00, 3'b000, 7'b1100111), row(5'b10011, 2'b00, 3'b111, 4'b0000, 1'b0));
    apply("LUI",   mk(7'h3c, 3'b110, 7'b0110111), row(5'b10001, 2'b01, 3'b000, 4'b1010, 1'b0));
    apply("AUIPC", mk(7'h3c, 3'b110, 7'b0010111), row(5'b10001, 2'b01, 3'b000, 4'b0000, 1'b0));

    // Illegal encodings, then confirm the sticky flag survives a legal ADD.
    apply("opcode 7f",     mk(7'h00, 3'b000, 7'b1111111), NOP_ILL);
    apply("R bad f7",      mk(7'h01, 3'b000, 7'b0110011), NOP_ILL);
    apply("SLLI bad f7",   mk(7'h20, 3'b001, 7'b0010011), NOP_ILL);
    apply("branch f3=010", mk(7'h00, 3'b010, 7'b1100011), NOP_ILL);
    apply("JALR f3=001",   mk(7'h00, 3'b001, 7'b1100111), NOP_ILL);
    apply("ADD after ill", mk(7'h00, 3'b000, 7'b0110011), row(5'b10010, 2'b01, 3'b000, 4'b0000, 1'b0));
    apply("ADD sticky",    mk(7'h00, 3'b000, 7'b0110011), row(5'b10010, 2'b01, 3'b000, 4'b0000, 1'b0));

    // Asynchronous reset away from any edge, with ADD applied.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    seen_model = 1'b0;
    exp_q.push_back('0);
    #1;
    compare_head("async reset");
    rst_n = 1'b1;
    exp_q.push_back(row(5'b10010, 2'b01, 3'b000, 4'b0000, 1'b0));
    #1;
    compare_head("async release");

    // Reset asserted on the same edge an illegal instruction would be captured.
    @(negedge clk);
    inst = mk(7'h00, 3'b000, 7'b1111111);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("reset beats edge", {31'd0, illegal_seen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(NOP_ILL);
    #1;
    compare_head("illegal after reset");
    @(posedge clk);
    #1;
    check("seen after edge", {31'd0, illegal_seen}, 32'd1);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
